// File: rtl/add64_share_seq_if.sv
// Request/response bundle for add64_share_seq: two requester channels and one tagged result channel.
interface add64_share_seq_if #(
    parameter int unsigned WORD_W = 32
);
    localparam int unsigned DW = 2 * WORD_W;

    logic          req0_valid;
    logic          req0_ready;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic          req0_cin;

    logic          req1_valid;
    logic          req1_ready;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic          req1_cin;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_sum;
    logic          rsp_cout;
    logic          rsp_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_sum, rsp_cout, rsp_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_sum, rsp_cout, rsp_id
    );
endinterface

// File: rtl/add64_share_seq.sv
// Two-beat 64-bit add on an external shared 32-bit adder, round-robin arbitrated
// between two requesters, with the result returned tagged by requester id.
module add64_share_seq #(
    parameter int unsigned WORD_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    add64_share_seq_if.slave      bus,
    output logic [WORD_W-1:0]     add_a,
    output logic [WORD_W-1:0]     add_b,
    output logic                  add_cin,
    input  logic [WORD_W-1:0]     add_sum
);
    localparam int unsigned DW = 2 * WORD_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e              state_q,     state_d;
    logic                rr_ptr_q,    rr_ptr_d;
    logic [DW-1:0]       a_q,         a_d;
    logic [DW-1:0]       b_q,         b_d;
    logic                cin_q,       cin_d;
    logic                id_q,        id_d;
    logic [WORD_W-1:0]   sum_lo_q,    sum_lo_d;
    logic [WORD_W-1:0]   sum_hi_q,    sum_hi_d;
    logic                c_mid_q,     c_mid_d;
    logic                cout_q,      cout_d;
    logic                rsp_valid_q, rsp_valid_d;

    logic                grant_c;
    logic                ready0_c;
    logic                ready1_c;
    logic [WORD_W-1:0]   op_a_c;
    logic [WORD_W-1:0]   op_b_c;
    logic                op_cin_c;
    logic                c31_c;
    logic                carry_c;

    // Contention goes to rr_ptr; a lone requester always wins.
    always_comb begin
        grant_c  = (bus.req0_valid && bus.req1_valid) ? rr_ptr_q : bus.req1_valid;
        ready0_c = (state_q == S_IDLE) && bus.req0_valid && !grant_c;
        ready1_c = (state_q == S_IDLE) && bus.req1_valid &&  grant_c;
    end

    // Adder operand select; idle, response and reset phases present zeros.
    always_comb begin
        op_a_c   = '0;
        op_b_c   = '0;
        op_cin_c = 1'b0;
        case (state_q)
            S_LO: begin
                op_a_c   = a_q[WORD_W-1:0];
                op_b_c   = b_q[WORD_W-1:0];
                op_cin_c = cin_q;
            end
            S_HI: begin
                op_a_c   = a_q[DW-1:WORD_W];
                op_b_c   = b_q[DW-1:WORD_W];
                op_cin_c = c_mid_q;
            end
            default: ;
        endcase
    end

    // Carry out of the word recovered from the sum MSB, since the adder exports no carry.
    always_comb begin
        c31_c   = add_sum[WORD_W-1] ^ op_a_c[WORD_W-1] ^ op_b_c[WORD_W-1];
        carry_c = (op_a_c[WORD_W-1] & op_b_c[WORD_W-1]) |
                  (op_a_c[WORD_W-1] & c31_c) |
                  (op_b_c[WORD_W-1] & c31_c);
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        id_d        = id_q;
        sum_lo_d    = sum_lo_q;
        sum_hi_d    = sum_hi_q;
        c_mid_d     = c_mid_q;
        cout_d      = cout_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            S_IDLE: begin
                if (ready0_c || ready1_c) begin
                    state_d  = S_LO;
                    id_d     = grant_c;
                    rr_ptr_d = !grant_c;
                    a_d      = grant_c ? bus.req1_a   : bus.req0_a;
                    b_d      = grant_c ? bus.req1_b   : bus.req0_b;
                    cin_d    = grant_c ? bus.req1_cin : bus.req0_cin;
                end
            end
            S_LO: begin
                sum_lo_d = add_sum;
                c_mid_d  = carry_c;
                state_d  = S_HI;
            end
            S_HI: begin
                sum_hi_d    = add_sum;
                cout_d      = carry_c;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            id_q        <= 1'b0;
            sum_lo_q    <= '0;
            sum_hi_q    <= '0;
            c_mid_q     <= 1'b0;
            cout_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            id_q        <= id_d;
            sum_lo_q    <= sum_lo_d;
            sum_hi_q    <= sum_hi_d;
            c_mid_q     <= c_mid_d;
            cout_q      <= cout_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req0_ready = ready0_c;
    assign bus.req1_ready = ready1_c;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_sum    = {sum_hi_q, sum_lo_q};
    assign bus.rsp_cout   = cout_q;
    assign bus.rsp_id     = id_q;

    assign add_a   = op_a_c;
    assign add_b   = op_b_c;
    assign add_cin = op_cin_c;

endmodule

// File: tb/tb_add64_share_seq.sv
// Bench for add64_share_seq: directed requests, a queue of expected results and a separate response monitor.
module tb_add64_share_seq;
    logic        clk;
    logic        rst;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;

    add64_share_seq_if #(.WORD_W(32)) bus ();

    add64_share_seq #(.WORD_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_cin (add_cin),
        .add_sum (add_sum)
    );

    // External shared adder.
    assign add_sum = add_a + add_b + {31'd0, add_cin};

    typedef struct packed {
        logic        id;
        logic [63:0] sum;
        logic        cout;
    } exp_t;

    exp_t sb[$];
    int   g_id[$];
    int   g_cyc[$];
    int   r_cyc[$];
    int   cyc;
    int   rsp_cnt;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: grant log and scoreboard compare on every response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req0_valid && bus.req0_ready) begin g_id.push_back(0); g_cyc.push_back(cyc); end
            if (bus.req1_valid && bus.req1_ready) begin g_id.push_back(1); g_cyc.push_back(cyc); end
            if (bus.req0_ready && bus.req1_ready) begin
                checks++; errors++;
                $display("FAIL both_ready actual=1 expected=0");
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                exp_t e;
                checks++;
                rsp_cnt++;
                r_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp id=%0d sum=%h", bus.rsp_id, bus.rsp_sum);
                end else begin
                    e = sb.pop_front();
                    if (bus.rsp_id !== e.id || bus.rsp_sum !== e.sum || bus.rsp_cout !== e.cout) begin
                        errors++;
                        $display("FAIL rsp actual id=%0d sum=%h cout=%0d expected id=%0d sum=%h cout=%0d",
                                 bus.rsp_id, bus.rsp_sum, bus.rsp_cout, e.id, e.sum, e.cout);
                    end
                end
            end
        end
    end

    task automatic issue(input bit id, input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic [63:0] es, input logic ec);
        bit   done;
        exp_t e;
        done = 1'b0;
        if (id == 1'b0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if ((id == 1'b0 && bus.req0_ready) || (id == 1'b1 && bus.req1_ready)) begin
                e.id = id; e.sum = es; e.cout = ec;
                sb.push_back(e);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (id == 1'b0) bus.req0_valid = 1'b0;
        else            bus.req1_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL grant_timeout id=%0d actual=no_grant expected=grant", id);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit rose;
        cyc = 0; rsp_cnt = 0; checks = 0; errors = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_sum",   bus.rsp_sum,        64'd0);
        chk("rst_rsp_cout",  64'(bus.rsp_cout),  64'd0);
        chk("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
        chk("rst_ready",     64'({bus.req1_ready, bus.req0_ready}), 64'd0);
        chk("rst_add",       {31'd0, add_cin, add_b}, 64'd0);
        chk("rst_add_a",     64'(add_a), 64'd0);
        @(posedge clk); #1;

        // Carry across word boundary, with latency
        g_cyc.delete(); g_id.delete(); r_cyc.delete();
        issue(1'b0, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 64'h00000001_00000000, 1'b0);
        wait_drain();
        if (g_cyc.size() == 1 && r_cyc.size() == 1)
            chk("latency", 64'(r_cyc[0] - g_cyc[0]), 64'd3);
        else
            chk("latency_events", 64'(g_cyc.size() + r_cyc.size()), 64'd2);

        // Full wrap with adder-input checks in LO and HI
        issue(1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b1, 64'h0, 1'b1);
        @(negedge clk);
        chk("lo_add_a",   64'(add_a),   64'hFFFFFFFF);
        chk("lo_add_b",   64'(add_b),   64'h0);
        chk("lo_add_cin", 64'(add_cin), 64'd1);
        @(negedge clk);
        chk("hi_add_a",   64'(add_a),   64'hFFFFFFFF);
        chk("hi_add_cin", 64'(add_cin), 64'd1);
        wait_drain();

        // Fairness with both requesters continuously valid
        g_cyc.delete(); g_id.delete();
        fork
            begin
                issue(1'b0, 64'h12345678_9ABCDEF0, 64'h11111111_11111111, 1'b0, 64'h23456789_ABCDF001, 1'b0);
                issue(1'b0, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 64'h80000000_00000000, 1'b0);
            end
            begin
                issue(1'b1, 64'h80000000_00000000, 64'h80000000_00000000, 1'b0, 64'h0, 1'b1);
                issue(1'b1, 64'h00000001_80000000, 64'h00000002_80000000, 1'b1, 64'h00000004_00000001, 1'b0);
            end
        join
        wait_drain();
        chk("fair_grants", 64'(g_id.size()), 64'd4);
        if (g_id.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("fair_id", 64'(g_id[i]), 64'(i % 2));
                if (i > 0) chk("fair_gap", 64'(g_cyc[i] - g_cyc[i-1]), 64'd4);
            end
        end

        // Backpressure for 5 cycles in RESP while requester 1 waits
        g_cyc.delete(); g_id.delete(); r_cyc.delete();
        bus.rsp_ready = 1'b0;
        issue(1'b0, 64'hFFFFFFFF_00000000, 64'h00000001_00000005, 1'b0, 64'h00000000_00000005, 1'b1);
        fork
            issue(1'b1, 64'h0000000A_0000000B, 64'h00000014_00000015, 1'b1, 64'h0000001E_00000021, 1'b0);
            begin
                for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
                    chk("bp_sum",   bus.rsp_sum, 64'h00000000_00000005);
                    chk("bp_meta",  64'({bus.rsp_id, bus.rsp_cout}), 64'd1);
                    chk("bp_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
                    chk("bp_add",   {31'd0, add_cin, add_a}, 64'd0);
                end
                @(posedge clk); #1;
                bus.rsp_ready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_rsp_count", 64'(r_cyc.size()), 64'd2);
        chk("bp_grants",    64'(g_id.size()), 64'd2);
        if (g_id.size() == 2 && r_cyc.size() == 2) begin
            chk("bp_next_id",    64'(g_id[1]), 64'd1);
            chk("bp_next_grant", 64'(g_cyc[1] - r_cyc[0]), 64'd1);
        end

        // Reset in HI aborts the operation and rr_ptr returns to 0
        issue(1'b0, 64'h5, 64'h6, 1'b0, 64'hB, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        if (sb.size() > 0) void'(sb.pop_back());
        rose = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) rose = 1'b1;
        end
        chk("midrst_no_rsp", 64'(rose), 64'd0);
        @(posedge clk); #1;
        g_cyc.delete(); g_id.delete();
        fork
            issue(1'b0, 64'h1, 64'h2, 1'b1, 64'h4, 1'b0);
            issue(1'b1, 64'hDEADBEEF_00000000, 64'h00000000_CAFEBABE, 1'b0, 64'hDEADBEEF_CAFEBABE, 1'b0);
        join
        wait_drain();
        chk("post_grants", 64'(g_id.size()), 64'd2);
        if (g_id.size() == 2) begin
            chk("post_first_id",  64'(g_id[0]), 64'd0);
            chk("post_second_id", 64'(g_id[1]), 64'd1);
        end

        chk("total_rsp", 64'(rsp_cnt), 64'd10);
        chk("sb_empty",  64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
